// File: rtl/datapath_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : datapath_sequencer
// Description : Multi-cycle controller between instruction decode and the
//               register-file/ALU datapath. It accepts one decoded
//               instruction and steps it through EXEC -> WB -> DONE. It
//               captures the ALU result and presents it on a valid/ready
//               port. It also counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    // decoded instruction handshake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_op,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_imm,
    input  logic             in_use_reg,
    input  logic             abort,
    // datapath control
    output logic [6:0]       dp_op,
    output logic [4:0]       dp_addr_a,
    output logic [4:0]       dp_addr_b,
    output logic [4:0]       dp_addr_d,
    output logic [31:0]      dp_immed,
    output logic             dp_y_sel,
    output logic             dp_write,
    input  logic [31:0]      dp_w,
    // result handshake
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [4:0]       res_rd,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_capture;
    logic              w_retire;

    logic [6:0]        r_op;
    logic [4:0]        r_rs1;
    logic [4:0]        r_rs2;
    logic [4:0]        r_rd;
    logic [31:0]       r_imm;
    logic              r_use_reg;
    logic [31:0]       r_res_data;
    logic [CNT_W-1:0]  r_retired;

    // State register; reset discards any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state handshake/write strobes
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        dp_write  = 1'b0;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else begin
                    w_capture = 1'b1;
                    w_next    = S_WB;
                end
            end
            S_WB: begin
                // r0 is hardwired; reset suppresses a write in flight
                dp_write = (r_rd != 5'd0) && !reset;
                w_next   = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Holding registers for the accepted instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= 7'd0;
            r_rs1     <= 5'd0;
            r_rs2     <= 5'd0;
            r_rd      <= 5'd0;
            r_imm     <= 32'd0;
            r_use_reg <= 1'b0;
        end else if (w_accept) begin
            r_op      <= in_op;
            r_rs1     <= in_rs1;
            r_rs2     <= in_rs2;
            r_rd      <= in_rd;
            r_imm     <= in_imm;
            r_use_reg <= in_use_reg;
        end
    end

    // Capture the ALU result at the end of a non-aborted EXEC cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_data <= 32'd0;
        end else if (w_capture) begin
            r_res_data <= dp_w;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign dp_op     = r_op;
    assign dp_addr_a = r_rs1;
    assign dp_addr_b = r_rs2;
    assign dp_addr_d = r_rd;
    assign dp_immed  = r_imm;
    assign dp_y_sel  = r_use_reg;
    assign res_data  = r_res_data;
    assign res_rd    = r_rd;
    assign retired   = r_retired;

endmodule
`default_nettype wire
